// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module : display_pkg
// Brief  : Shared capture FSM state type and 7-segment code table.
// Rev    : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_HELD   = 1'b1
    } cap_state_t;

    // Active-low gfedcba patterns for hex digits 0..F, indexed by value.
    localparam logic [6:0] c_seg_codes [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module : seg7_decoder
// Brief  : Combinational inverse of the 7-segment encoder (pattern -> nibble).
// Rev    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import display_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_valid
);

    always_comb begin
        o_value = 4'h0;
        o_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == c_seg_codes[i]) begin
                o_value = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_capture.sv
`default_nettype none
// ============================================================================
// Module : display_capture
// Brief  : Snoops a multiplexed 8-digit 7-segment bus and rebuilds 32-bit frames.
// Rev    : 1.0 - initial release
// ============================================================================
module display_capture
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  AN,
    input  logic [6:0]  segmentos,
    output logic [31:0] hora_capturada,
    output logic        frame_valid,
    output logic        decode_error,
    output logic        timeout
);

    localparam int             c_idle_w      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     c_stable_last = 8'(STABLE_CYCLES - 2);

    logic [7:0]          r_s_an, r_p_an;
    logic [6:0]          r_s_seg, r_p_seg;
    cap_state_t          r_state, w_state_nxt;
    logic [7:0]          r_stable_cnt, w_stable_nxt;
    logic [c_idle_w-1:0] r_idle;
    logic [7:0]          r_mask;
    logic [31:0]         r_shadow;
    logic                w_candidate, w_same, w_accept, w_dec_valid;
    logic [3:0]          w_dec_value;
    logic [2:0]          w_digit;
    logic [7:0]          w_digit_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_an  <= 8'hFF;
            r_s_seg <= 7'h7F;
            r_p_an  <= 8'hFF;
            r_p_seg <= 7'h7F;
        end else begin
            r_s_an  <= AN;
            r_s_seg <= segmentos;
            r_p_an  <= r_s_an;
            r_p_seg <= r_s_seg;
        end
    end

    assign w_candidate = ($countones(~r_s_an) == 1);
    assign w_same      = ({r_s_an, r_s_seg} == {r_p_an, r_p_seg});

    always_comb begin
        w_digit = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_s_an[i]) w_digit = 3'(i);
        end
    end
    assign w_digit_bit = 8'h01 << w_digit;

    seg7_decoder u_dec (
        .i_seg   (r_s_seg),
        .o_value (w_dec_value),
        .o_valid (w_dec_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_SETTLE;
            r_stable_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_stable_cnt <= w_stable_nxt;
        end
    end

    // The counter is left at STABLE_CYCLES-1 while HELD so a steady digit is taken once.
    always_comb begin
        w_state_nxt  = r_state;
        w_stable_nxt = r_stable_cnt;
        w_accept     = 1'b0;
        if (!w_candidate) begin
            w_state_nxt  = ST_SETTLE;
            w_stable_nxt = 8'd0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (!w_same) begin
                        w_stable_nxt = 8'd0;
                    end else begin
                        w_stable_nxt = r_stable_cnt + 8'd1;
                        if (r_stable_cnt == c_stable_last) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_HELD;
                        end
                    end
                end
                ST_HELD: begin
                    if (!w_same) begin
                        w_state_nxt  = ST_SETTLE;
                        w_stable_nxt = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt  = ST_SETTLE;
                    w_stable_nxt = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle         <= '0;
            r_mask         <= 8'h00;
            r_shadow       <= 32'h0;
            hora_capturada <= 32'h0;
            frame_valid    <= 1'b0;
            decode_error   <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            frame_valid  <= 1'b0;
            decode_error <= 1'b0;
            timeout      <= 1'b0;

            if (w_accept)
                r_idle <= '0;
            else if (r_idle != c_idle_max)
                r_idle <= r_idle + c_idle_w'(1);

            if (w_accept && w_dec_valid)
                r_shadow[{w_digit, 2'b00} +: 4] <= w_dec_value;

            // Bad pattern outranks completion; completion outranks inactivity.
            if (w_accept && !w_dec_valid) begin
                decode_error <= 1'b1;
                r_mask       <= 8'h00;
            end else if (r_mask == 8'hFF) begin
                hora_capturada <= r_shadow;
                frame_valid    <= 1'b1;
                r_mask         <= w_accept ? w_digit_bit : 8'h00;
            end else if (w_accept) begin
                r_mask <= r_mask | w_digit_bit;
            end else if ((r_idle == c_idle_max) && (r_mask != 8'h00)) begin
                r_mask  <= 8'h00;
                timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_display_capture
// Brief  : Self-checking bench for display_capture with a frame scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_display_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 50;
    localparam int DIG    = 8;

    typedef struct {
        logic [31:0] value;
        int          rot;
        bit          rev;
        logic [31:0] exp_hora;
    } frame_vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  AN = 8'hFF;
    logic [6:0]  segmentos = 7'h7F;
    logic [31:0] hora_capturada;
    logic        frame_valid, decode_error, timeout;

    int n_vec = 0, n_fail = 0;
    int fv_cnt = 0, err_cnt = 0, to_cnt = 0;
    int f0, e0, t0, c;
    logic [31:0] exp_q [$];
    frame_vec_t  vecs [5];

    always #5 clk = ~clk;

    display_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .AN             (AN),
        .segmentos      (segmentos),
        .hora_capturada (hora_capturada),
        .frame_valid    (frame_valid),
        .decode_error   (decode_error),
        .timeout        (timeout)
    );

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every frame_valid pops one expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid === 1'b1) begin
                fv_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL frame_unexpected: actual=%h required=no frame", hora_capturada);
                end else begin
                    check("frame_hora", hora_capturada, exp_q.pop_front());
                end
            end
            if (decode_error === 1'b1) err_cnt++;
            if (timeout === 1'b1) to_cnt++;
        end
    end

    task automatic put(input logic [7:0] an, input logic [6:0] seg, input int n);
        AN = an;
        segmentos = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int k, input logic [6:0] seg, input int n);
        put(~(8'h01 << k), seg, n);
    endtask

    task automatic send_digits(input logic [31:0] val, input logic [7:0] which);
        for (int k = 0; k < 8; k++) begin
            if (which[k]) begin
                digit(k, enc(val[4*k +: 4]), DIG);
                put(8'hFF, 7'h7F, 2);
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h9ABCDEF0, 3, 1'b0, 32'h9ABCDEF0};
        vecs[1] = '{32'hFEDCBA98, 0, 1'b1, 32'hFEDCBA98};
        vecs[2] = '{32'h0F1E2D3C, 5, 1'b1, 32'h0F1E2D3C};
        vecs[3] = '{32'h00000000, 2, 1'b0, 32'h00000000};
        vecs[4] = '{32'h8899AABB, 7, 1'b0, 32'h8899AABB};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hora", hora_capturada, 32'h0);
        check("rst_flags", {29'h0, frame_valid, decode_error, timeout}, 32'h0);
        reset = 1'b0;
        put(8'hFF, 7'h7F, 4);

        // Looped-back driver: continuous digit scan, two frames in 16 periods
        f0 = fv_cnt;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h12345678);
        for (int p = 0; p < 16; p++) begin
            logic [31:0] v;
            v = 32'h12345678;
            digit(p % 8, enc(v[4*(p%8) +: 4]), DIG);
        end
        put(8'hFF, 7'h7F, 2);
        wait_drain("driver_frames", 4);
        check("driver_fv_count", fv_cnt - f0, 2);

        // Latency from the 8th digit at the pins to frame_valid
        exp_q.push_back(32'hA5A53C3C);
        send_digits(32'hA5A53C3C, 8'h7F);
        AN = 8'h7F;
        segmentos = enc(4'hA);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (frame_valid !== 1'b1 && c < 30);
        check("latency", c, STABLE + 2);
        put(8'hFF, 7'h7F, 3);
        wait_drain("latency_frame", 4);

        // Table-driven frames in permuted digit orders
        e0 = err_cnt;
        t0 = to_cnt;
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].exp_hora);
            for (int i = 0; i < 8; i++) begin
                int k;
                k = (i + vecs[v].rot) % 8;
                if (vecs[v].rev) k = 7 - k;
                digit(k, enc(vecs[v].value[4*k +: 4]), DIG);
                put(8'hFF, 7'h7F, 2);
            end
            wait_drain("table_frame", 10);
        end
        check("table_no_flags", (err_cnt - e0) + (to_cnt - t0), 0);

        // One-cycle glitch during digit 5
        exp_q.push_back(32'h13572468);
        f0 = fv_cnt;
        send_digits(32'h13572468, 8'hDF);
        digit(5, enc(4'h5), 3);
        digit(5, enc(4'hE), 1);
        digit(5, enc(4'h5), 3);
        put(8'hFF, 7'h7F, 2);
        check("glitch_no_accept", fv_cnt - f0, 0);
        digit(5, enc(4'h5), 4);
        put(8'hFF, 7'h7F, 3);
        wait_drain("glitch_frame", 10);

        // Blank pattern on digit 3 must abort the frame
        e0 = err_cnt;
        f0 = fv_cnt;
        send_digits(32'h44444444, 8'h07);
        digit(3, 7'h7F, DIG);
        put(8'hFF, 7'h7F, 2);
        check("decerr_pulse", err_cnt - e0, 1);
        send_digits(32'h44444444, 8'hF8);
        check("decerr_no_frame", fv_cnt - f0, 0);
        put(8'hFF, 7'h7F, 70);

        // Two anodes enabled at once
        f0 = fv_cnt;
        e0 = err_cnt;
        t0 = to_cnt;
        put(8'hFC, enc(4'h5), 100);
        put(8'hFF, 7'h7F, 2);
        check("multi_an_no_flags", (fv_cnt - f0) + (err_cnt - e0) + (to_cnt - t0), 0);
        send_digits(32'h55555555, 8'hFE);
        check("multi_an_no_accept", fv_cnt - f0, 0);
        put(8'hFF, 7'h7F, 70);

        // Inactivity timeout after 5 digits, then a clean frame
        t0 = to_cnt;
        send_digits(32'h66666666, 8'h0F);
        digit(4, enc(4'h6), DIG);
        AN = 8'hFF;
        segmentos = 7'h7F;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (timeout !== 1'b1 && c < 200);
        check("timeout_latency", c, TMO + STABLE - DIG + 1);
        put(8'hFF, 7'h7F, 100);
        check("timeout_once", to_cnt - t0, 1);
        exp_q.push_back(32'hC0FFEE42);
        send_digits(32'hC0FFEE42, 8'hFF);
        wait_drain("post_timeout_frame", 10);

        // Reset mid-frame
        send_digits(32'h77777777, 8'h3F);
        f0 = fv_cnt;
        e0 = err_cnt;
        t0 = to_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_hora", hora_capturada, 32'h0);
        check("midrst_flags", {29'h0, frame_valid, decode_error, timeout}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        put(8'hFF, 7'h7F, 80);
        check("midrst_silent", (fv_cnt - f0) + (err_cnt - e0) + (to_cnt - t0), 0);
        exp_q.push_back(32'h8765ABCD);
        send_digits(32'h8765ABCD, 8'hFF);
        wait_drain("post_reset_frame", 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples needed to accept a digit (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum number of cycles between accepted digits before the partial frame is discarded.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port AN, input, 8 bits: multiplexed anode enables, active-low, with bit k selecting digit k.
REQ-006 SHALL have port segmentos, input, 7 bits: segment lines, active-low, with bit0=a through bit6=g.
REQ-007 SHALL have port hora_capturada, output, 32 bits: the last complete frame; digit k occupies bits [4k+3:4k].
REQ-008 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when hora_capturada updates.
REQ-009 SHALL have port decode_error, output, 1 bit: one-cycle pulse on an accepted but undecodable segment pattern.
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse when a partial frame is discarded for inactivity.

Function
REQ-011 SHALL register AN and segmentos once (stage S); all further logic uses S and the previous-cycle copy P.
REQ-012 SHALL treat a sample as candidate only when S.AN has exactly one zero bit; otherwise the stability counter clears and the FSM goes to SETTLE.
REQ-013 SHALL implement FSM states SETTLE and HELD; reset state is SETTLE.
REQ-014 In SETTLE, SHALL increment the stability counter while the sample is a candidate and S==P, and SHALL clear it to 0 when S!=P.
REQ-015 SHALL accept the digit in the cycle the counter reaches STABLE_CYCLES-1, then go to HELD.
REQ-016 In HELD, SHALL accept nothing and SHALL return to SETTLE (counter 0) on the first cycle S!=P.
REQ-017 SHALL decode accepted patterns (active-low, gfedcba) 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E hex to the values 0..F.
REQ-018 On a valid accept, SHALL write the nibble to digit k of a shadow word and set mask bit k; re-accepting the same k overwrites it.
REQ-019 On an invalid pattern, SHALL pulse decode_error the next cycle, clear the mask, and leave the shadow word unchanged.
REQ-020 When the mask becomes 8'hFF, the next cycle SHALL copy the shadow word (including the digit just written) to hora_capturada, pulse frame_valid, and clear the mask.
REQ-021 The latency from the first stable cycle of the 8th digit at the pins to frame_valid SHALL be STABLE_CYCLES+2 cycles.
REQ-022 SHALL run an inactivity counter that resets on every accept and saturates; when it reaches TIMEOUT_CYCLES-1 with the mask nonzero, SHALL clear the mask and pulse timeout once.
REQ-023 If an invalid pattern and mask completion would coincide, decode_error SHALL take priority and frame_valid SHALL NOT pulse.
REQ-024 The digit order within a frame SHALL be irrelevant; only set membership in the mask counts.

Reset
REQ-025 While reset=1, SHALL hold hora_capturada=0, frame_valid=0, decode_error=0, timeout=0, mask=0, shadow=0, both counters=0, and S/P=all ones.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame without pulsing any flag.

Structure
REQ-027 SHALL place the FSM state enum and the 16-entry segment code constant table in a shared package, display_pkg.
REQ-028 SHALL use one sub-module, seg7_decoder (7-bit pattern in, 4-bit value plus valid flag out), which is purely combinational and the inverse of the existing segment encoder.

Verification
REQ-029 SHALL cover: the existing display driver looped back, displaying 32'h1234_5678 -> frame_valid pulses and hora_capturada=32'h12345678 within 16 digit periods.
REQ-030 SHALL cover: a one-cycle glitch on segmentos during a digit with STABLE_CYCLES=4 -> no accept until 4 identical samples, and the correct nibble is stored.
REQ-031 SHALL cover: segmentos=7'h7F (blank) on digit 3 -> decode_error pulses once, mask=0, and there is no frame_valid that frame.
REQ-032 SHALL cover: AN=8'hFC (two digits enabled) held for 100 cycles -> no accept and no flags.
REQ-033 SHALL cover: 5 digits followed by silence with TIMEOUT_CYCLES=50 -> timeout pulses once after 50 cycles, and a subsequent full frame is captured correctly.
REQ-034 SHALL cover: reset asserted after 6 digits -> all outputs read 0, and the next 8 digits produce a correct frame_valid.
